// File: rtl/vga_cap_pkg.sv
// Shared constants and the luma helper for the VGA window capture stage.
// Timing defaults describe a 512x512 window inside a standard 800-clock line.
package vga_cap_pkg;

    localparam logic [1:0] MODE_R    = 2'd0;
    localparam logic [1:0] MODE_G    = 2'd1;
    localparam logic [1:0] MODE_B    = 2'd2;
    localparam logic [1:0] MODE_LUMA = 2'd3;

    localparam int DEF_H_BACK   = 88;
    localparam int DEF_H_ACTIVE = 512;
    localparam int DEF_V_BACK   = 0;
    localparam int DEF_V_ACTIVE = 512;

    // Widest channel the luma helper accepts; callers zero-extend into it.
    localparam int LUMA_W = 16;

    function automatic logic [LUMA_W-1:0] luma(
        input logic [LUMA_W-1:0] r,
        input logic [LUMA_W-1:0] g,
        input logic [LUMA_W-1:0] b
    );
        logic [LUMA_W+1:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return LUMA_W'(sum >> 2);
    endfunction

endpackage

// File: rtl/vga_pix_select.sv
// Channel selector: picks R, G, B or (R+2G+B)>>2 for the current pixel.
// Purely combinational; the caller registers the result.
module vga_pix_select
    import vga_cap_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] r,
    input  logic [PIX_W-1:0] g,
    input  logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] sel
);

    always_comb begin
        sel = r;
        unique case (mode)
            MODE_R:  sel = r;
            MODE_G:  sel = g;
            MODE_B:  sel = b;
            default: sel = PIX_W'(luma(LUMA_W'(r), LUMA_W'(g), LUMA_W'(b)));
        endcase
    end

endmodule

// File: rtl/vga_window_capture.sv
// VGA capture stage: sync edge detect, saturating h/v position, window
// extraction and registered pixel/marker outputs two clocks after input.
module vga_window_capture
    import vga_cap_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int CNT_W     = 12,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int SKIP_ZERO = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] R,
    input  logic [PIX_W-1:0] G,
    input  logic [PIX_W-1:0] B,
    input  logic             HS,
    input  logic             VS,
    input  logic [1:0]       mode,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_pixel_valid,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PIX_W-1:0] r_a, g_a, b_a;
    logic [1:0]       mode_a;
    logic             hs_a, vs_a, hs_p, vs_p;

    logic [CNT_W-1:0] h_q, v_q;
    logic [1:0]       mode_q;
    logic             frame_armed;

    logic             hs_rise, vs_rise;
    logic [CNT_W-1:0] h_cur, v_cur;
    logic [1:0]       mode_cur;
    logic             in_win, h_sat_now;
    logic [PIX_W-1:0] sel;

    // Signed int arithmetic keeps saturated counters from wrapping into range.
    function automatic logic in_range(
        input logic [CNT_W-1:0] x,
        input int               lo,
        input int               n
    );
        int d;
        d = int'(x) - lo;
        return (d >= 0) && (d < n);
    endfunction

    always_comb begin
        hs_rise = hs_a & ~hs_p;
        vs_rise = vs_a & ~vs_p;

        h_cur = h_q;
        if (hs_rise)
            h_cur = '0;
        else if (h_q != CNT_MAX)
            h_cur = h_q + 1'b1;

        // VS parks v at saturation until the next HS starts line 0.
        v_cur = v_q;
        if (hs_rise) begin
            if (vs_rise || frame_armed)
                v_cur = '0;
            else if (v_q != CNT_MAX)
                v_cur = v_q + 1'b1;
        end else if (vs_rise) begin
            v_cur = CNT_MAX;
        end

        mode_cur  = vs_rise ? mode_a : mode_q;
        in_win    = in_range(h_cur, H_BACK, H_ACTIVE)
                 && in_range(v_cur, V_BACK, V_ACTIVE);
        h_sat_now = (h_q != CNT_MAX) && (h_cur == CNT_MAX);
    end

    vga_pix_select #(
        .PIX_W(PIX_W)
    ) u_sel (
        .mode(mode_cur),
        .r   (r_a),
        .g   (g_a),
        .b   (b_a),
        .sel (sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a             <= '0;
            g_a             <= '0;
            b_a             <= '0;
            mode_a          <= '0;
            hs_a            <= 1'b0;
            vs_a            <= 1'b0;
            hs_p            <= 1'b0;
            vs_p            <= 1'b0;
            h_q             <= CNT_MAX;
            v_q             <= CNT_MAX;
            mode_q          <= MODE_R;
            frame_armed     <= 1'b0;
            out_pixel       <= '0;
            out_pixel_valid <= 1'b0;
            out_sof         <= 1'b0;
            out_eol         <= 1'b0;
            out_err         <= 1'b0;
        end else begin
            r_a    <= R;
            g_a    <= G;
            b_a    <= B;
            mode_a <= mode;
            hs_a   <= HS;
            vs_a   <= VS;
            hs_p   <= hs_a;
            vs_p   <= vs_a;

            h_q    <= h_cur;
            v_q    <= v_cur;
            mode_q <= mode_cur;

            if (hs_rise)
                frame_armed <= 1'b0;
            else if (vs_rise)
                frame_armed <= 1'b1;

            out_pixel       <= in_win ? sel : '0;
            out_pixel_valid <= in_win && (SKIP_ZERO == 0 || sel != '0);
            out_sof         <= in_win && int'(h_cur) == H_BACK
                                      && int'(v_cur) == V_BACK;
            out_eol         <= in_win && int'(h_cur) == H_BACK + H_ACTIVE - 1;

            if (h_sat_now)
                out_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_window_capture.sv
// Scoreboard bench for vga_window_capture: expected outputs are queued per
// input sample from line position and compared two clocks later.
module tb_vga_window_capture;

    typedef struct {
        logic       valid;
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        int         h;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] R, G, B;
    logic       HS, VS;
    logic [1:0] mode;
    logic [7:0] out_pixel;
    logic       out_pixel_valid, out_sof, out_eol, out_err;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    string tname    = "none";

    vga_window_capture dut (
        .clk            (clk),
        .rst            (rst),
        .R              (R),
        .G              (G),
        .B              (B),
        .HS             (HS),
        .VS             (VS),
        .mode           (mode),
        .out_pixel      (out_pixel),
        .out_pixel_valid(out_pixel_valid),
        .out_sof        (out_sof),
        .out_eol        (out_eol),
        .out_err        (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t zero_exp();
        exp_t e;
        e.valid = 1'b0;
        e.pix   = 8'd0;
        e.sof   = 1'b0;
        e.eol   = 1'b0;
        e.h     = -1;
        return e;
    endfunction

    function automatic logic [7:0] exp_sel(input int m, input int r,
                                           input int g, input int b);
        int v;
        case (m)
            0:       v = r;
            1:       v = g;
            2:       v = b;
            default: v = (r + 2 * g + b) / 4;
        endcase
        return 8'(v);
    endfunction

    // Drive one sample at a negedge; compare every queued sample now due.
    task automatic step(input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic hs,
                        input logic vs, input logic [1:0] md,
                        input exp_t e);
        exp_t x;
        R = r; G = g; B = b; HS = hs; VS = vs; mode = md;
        exp_q.push_back(e);
        @(negedge clk);
        while (exp_q.size() >= 2) begin
            x = exp_q.pop_front();
            n_checks++;
            if ({out_pixel_valid, out_pixel, out_sof, out_eol}
                !== {x.valid, x.pix, x.sof, x.eol}) begin
                n_fail++;
                $display("FAIL %s h=%0d: got v=%b p=%0d sof=%b eol=%b, want v=%b p=%0d sof=%b eol=%b",
                         tname, x.h, out_pixel_valid, out_pixel, out_sof,
                         out_eol, x.valid, x.pix, x.sof, x.eol);
            end
        end
    endtask

    task automatic idle(input int n, input logic [1:0] md);
        for (int i = 0; i < n; i++)
            step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, md, zero_exp());
    endtask

    task automatic vs_pulse(input logic [1:0] md);
        step(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, md, zero_exp());
        step(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, md, zero_exp());
        step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, md, zero_exp());
        step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, md, zero_exp());
    endtask

    // One line of len samples; HS high on h=0 only.
    task automatic send_line(input bit in_v, input bit first,
                             input int exp_mode, input int pat,
                             input bit vs_too, input logic [1:0] md,
                             input int len);
        exp_t       e;
        logic [7:0] r, g, b, s;
        bit         inw;
        for (int h = 0; h < len; h++) begin
            case (pat)
                0:       begin r = 8'd5;   g = 8'd0;   b = 8'd0;   end
                1:       begin r = (h % 2 == 0) ? 8'd7 : 8'd0;
                               g = 8'd0;   b = 8'd0;   end
                2:       begin r = 8'd255; g = 8'd255; b = 8'd255; end
                3:       begin r = 8'd4;   g = 8'd0;   b = 8'd0;   end
                default: begin r = 8'd4;   g = 8'd9;   b = 8'd2;   end
            endcase
            s       = exp_sel(exp_mode, int'(r), int'(g), int'(b));
            inw     = in_v && h >= 88 && h < 600;
            e.valid = inw && s != 8'd0;
            e.pix   = inw ? s : 8'd0;
            e.sof   = inw && first && h == 88;
            e.eol   = inw && h == 599;
            e.h     = h;
            step(r, g, b, h == 0, vs_too && h == 0, md, e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        HS = 1'b0; VS = 1'b0; R = '0; G = '0; B = '0; mode = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string what);
        n_checks++;
        if ({out_pixel_valid, out_pixel, out_sof, out_eol, out_err} !== 12'd0) begin
            n_fail++;
            $display("FAIL %s: got v=%b p=%0d sof=%b eol=%b err=%b, want all 0",
                     what, out_pixel_valid, out_pixel, out_sof, out_eol, out_err);
        end
    endtask

    task automatic check_err(input string what, input logic want);
        n_checks++;
        if (out_err !== want) begin
            n_fail++;
            $display("FAIL %s: got out_err=%b, want %b", what, out_err, want);
        end
    endtask

    task automatic test_reset();
        tname = "reset";
        rst = 1'b1;
        HS = 1'b0; VS = 1'b0; R = 8'd5; G = '0; B = '0; mode = 2'd0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst = 1'b0;
        exp_q.delete();
        tname = "no_vs_after_reset";
        send_line(0, 0, 0, 0, 0, 2'd0, 620);
        idle(2, 2'd0);
    endtask

    task automatic test_basic();
        tname = "basic_r5";
        vs_pulse(2'd0);
        send_line(1, 1, 0, 0, 0, 2'd0, 620);
    endtask

    task automatic test_skip_zero();
        tname = "skip_zero";
        send_line(1, 0, 0, 1, 0, 2'd0, 620);
        idle(2, 2'd0);
    endtask

    task automatic test_luma_mode();
        tname = "luma_max";
        vs_pulse(2'd3);
        send_line(1, 1, 3, 2, 0, 2'd3, 620);
        tname = "luma_r4";
        send_line(1, 0, 3, 3, 0, 2'd3, 620);
        tname = "mode_mid_frame";
        send_line(1, 0, 3, 4, 0, 2'd1, 620);
        tname = "mode_next_frame";
        vs_pulse(2'd1);
        send_line(1, 1, 1, 4, 0, 2'd1, 620);
        idle(2, 2'd0);
    endtask

    task automatic test_vs_hs_same();
        tname = "vs_hs_same";
        send_line(1, 1, 0, 0, 1, 2'd0, 620);
        tname = "short_lines";
        for (int l = 1; l < 512; l++)
            send_line(0, 0, 0, 0, 0, 2'd0, 4);
        tname = "line_512";
        send_line(0, 0, 0, 0, 0, 2'd0, 620);
        idle(2, 2'd0);
    endtask

    task automatic test_err();
        tname = "err";
        do_reset();
        check_err("err_after_reset", 1'b0);
        vs_pulse(2'd0);
        send_line(1, 1, 0, 0, 0, 2'd0, 4095);
        check_err("err_before_sat", 1'b0);
        idle(4, 2'd0);
        check_err("err_after_sat", 1'b1);
        do_reset();
        check_err("err_cleared_by_rst", 1'b0);
    endtask

    task automatic test_reset_mid();
        tname = "reset_mid";
        vs_pulse(2'd0);
        send_line(1, 1, 0, 0, 0, 2'd0, 301);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset_mid_window");
        rst = 1'b0;
        exp_q.delete();
        tname = "after_rst_no_vs";
        send_line(0, 0, 0, 0, 0, 2'd0, 620);
        tname = "after_rst_new_frame";
        vs_pulse(2'd0);
        send_line(1, 1, 0, 0, 0, 2'd0, 620);
        idle(2, 2'd0);
    endtask

    initial begin
        rst = 1'b1;
        HS = 1'b0; VS = 1'b0; R = '0; G = '0; B = '0; mode = 2'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_skip_zero();
        test_luma_mode();
        test_vs_hs_same();
        test_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
